ram_share_arb: RTL

Two-requester arbiter for the CPU's single-port data RAM (8K × 32, 13-bit word address). It shares the RAM between the CPU data port and the external host load port (the i_ram_* path used to preload programs and inspect memory). Grants are decided per cycle, with fair alternation under contention. The block stalls the CPU while the host owns the port and routes the 1-cycle-latency read data back to the correct requester.

---
 rtl/mips_mem_pkg.sv | 13 +
 rtl/ram_share_arb_if.sv | 47 ++++
 rtl/arb_sat_cnt.sv | 23 ++
 rtl/ram_share_arb.sv | 127 ++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the CPU data-RAM sharing logic: RAM geometry and port-owner encoding.
package mips_mem_pkg;

    localparam int unsigned RAM_ADDR_W = 13;
    localparam int unsigned RAM_DATA_W = 32;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_HOST = 2'd2
    } owner_e;

endpackage

// File: rtl/ram_share_arb_if.sv
// Bundle of the CPU port, host load port and RAM port seen by ram_share_arb.
interface ram_share_arb_if
    import mips_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = RAM_ADDR_W,
    parameter int unsigned DATA_W = RAM_DATA_W
);

    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_wen;
    logic              cpu_stall;
    logic [DATA_W-1:0] cpu_rdata;

    logic              host_req;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_wen;
    logic              host_gnt;
    logic              host_rvalid;
    logic [DATA_W-1:0] host_rdata;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_wen;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  cpu_req, cpu_addr, cpu_wdata, cpu_wen,
        input  host_req, host_addr, host_wdata, host_wen,
        input  ram_rdata,
        output cpu_stall, cpu_rdata,
        output host_gnt, host_rvalid, host_rdata,
        output ram_addr, ram_wdata, ram_wen
    );

    modport master (
        output cpu_req, cpu_addr, cpu_wdata, cpu_wen,
        output host_req, host_addr, host_wdata, host_wen,
        output ram_rdata,
        input  cpu_stall, cpu_rdata,
        input  host_gnt, host_rvalid, host_rdata,
        input  ram_addr, ram_wdata, ram_wen
    );

endinterface

// File: rtl/arb_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module arb_sat_cnt #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + WIDTH'(1);
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/ram_share_arb.sv
// Shares the single-port data RAM between the CPU and the host load port with fair alternation.
// Define ARB_HOST_BURST_EN to let the host hold the port for up to HOST_BURST contended beats.
module ram_share_arb
    import mips_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = RAM_ADDR_W,
    parameter int unsigned DATA_W = RAM_DATA_W
`ifdef ARB_HOST_BURST_EN
    ,
    parameter int unsigned HOST_BURST = 4
`endif
) (
    input  logic            clk,
    input  logic            reset,
    ram_share_arb_if.slave  bus,
    output logic [15:0]     stall_cnt
);

    owner_e            gnt;
    owner_e            last_q, last_d;
    owner_e            rd_owner_q, rd_owner_d;
    logic              host_wins;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_wdata;
    logic              gnt_wen;
    logic [DATA_W-1:0] cpu_rdata_q, host_rdata_q;

`ifdef ARB_HOST_BURST_EN
    localparam int unsigned BurstW = $clog2(HOST_BURST + 1);

    logic [BurstW-1:0] burst_q, burst_d;

    // Host keeps the port under contention until it has used its burst allowance.
    assign host_wins = (last_q == OWN_CPU) || (burst_q < BurstW'(HOST_BURST));

    always_comb begin
        burst_d = burst_q;
        if ((gnt == OWN_CPU) || !bus.host_req) begin
            burst_d = '0;
        end else if ((gnt == OWN_HOST) && bus.cpu_req) begin
            burst_d = burst_q + BurstW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            burst_q <= '0;
        end else begin
            burst_q <= burst_d;
        end
    end
`else
    assign host_wins = (last_q == OWN_CPU);
`endif

    always_comb begin
        gnt = OWN_NONE;
        if (!reset) begin
            if (bus.cpu_req && bus.host_req) begin
                gnt = host_wins ? OWN_HOST : OWN_CPU;
            end else if (bus.cpu_req) begin
                gnt = OWN_CPU;
            end else if (bus.host_req) begin
                gnt = OWN_HOST;
            end
        end
    end

    always_comb begin
        gnt_addr  = '0;
        gnt_wdata = '0;
        gnt_wen   = 1'b0;
        unique case (gnt)
            OWN_CPU: begin
                gnt_addr  = bus.cpu_addr;
                gnt_wdata = bus.cpu_wdata;
                gnt_wen   = bus.cpu_wen;
            end
            OWN_HOST: begin
                gnt_addr  = bus.host_addr;
                gnt_wdata = bus.host_wdata;
                gnt_wen   = bus.host_wen;
            end
            default: ;
        endcase
    end

    assign bus.ram_addr  = gnt_addr;
    assign bus.ram_wdata = gnt_wdata;
    assign bus.ram_wen   = gnt_wen;
    assign bus.cpu_stall = bus.cpu_req && (gnt != OWN_CPU) && !reset;
    assign bus.host_gnt  = (gnt == OWN_HOST);

    always_comb begin
        last_d     = (gnt == OWN_NONE) ? last_q : gnt;
        rd_owner_d = (gnt != OWN_NONE && !gnt_wen) ? gnt : OWN_NONE;
    end

    // A read in flight when reset rises is dropped rather than delivered.
    assign bus.host_rvalid = (rd_owner_q == OWN_HOST) && !reset;
    assign bus.host_rdata  = bus.host_rvalid ? bus.ram_rdata : host_rdata_q;
    assign bus.cpu_rdata   = ((rd_owner_q == OWN_CPU) && !reset) ? bus.ram_rdata : cpu_rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q       <= OWN_CPU;
            rd_owner_q   <= OWN_NONE;
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
        end else begin
            last_q       <= last_d;
            rd_owner_q   <= rd_owner_d;
            cpu_rdata_q  <= bus.cpu_rdata;
            host_rdata_q <= bus.host_rdata;
        end
    end

    arb_sat_cnt #(
        .WIDTH(16)
    ) u_stall_cnt (
        .clk(clk),
        .clr(reset),
        .inc(bus.cpu_stall),
        .cnt(stall_cnt)
    );

endmodule
